// File: rtl/clk_ratio_detector_if.sv
// clk_ratio_detector_if
//   Groups the detector's enable, the clock under measurement and the
//   measurement results into one bundle.
//   master : drives i_en / i_meas_clk and observes the results (controller, bench)
//   slave  : the detector itself
//   i_en        detector enable
//   i_meas_clk  clock under measurement (asynchronous, sampled as data)
//   o_ratio     last measured period in reference cycles
//   o_high_cnt  last measured high-phase length in reference cycles
//   o_valid     one-cycle pulse when o_ratio / o_high_cnt update
//   o_locked    enough consecutive equal periods seen
//   o_timeout   no rising edge within MAX_RATIO cycles (sticky)
interface clk_ratio_detector_if;
  logic       i_en;
  logic       i_meas_clk;
  logic [7:0] o_ratio;
  logic [7:0] o_high_cnt;
  logic       o_valid;
  logic       o_locked;
  logic       o_timeout;

  modport master (
    output i_en, i_meas_clk,
    input  o_ratio, o_high_cnt, o_valid, o_locked, o_timeout
  );

  modport slave (
    input  i_en, i_meas_clk,
    output o_ratio, o_high_cnt, o_valid, o_locked, o_timeout
  );
endinterface

// File: rtl/clk_ratio_detector.sv
// clk_ratio_detector
//   Measures the period and high-phase length of a slow clock by sampling it
//   as data in the reference domain, and reports lock once LOCK_COUNT
//   consecutive periods agree.
//   i_ref_clk  reference clock (sole clock)
//   i_rst      synchronous, active-high reset
//   bus        clk_ratio_detector_if.slave (enable, measured clock, results)
module clk_ratio_detector #(
  parameter int unsigned MAX_RATIO  = 255,
  parameter int unsigned LOCK_COUNT = 4
) (
  input logic                 i_ref_clk,
  input logic                 i_rst,
  clk_ratio_detector_if.slave bus
);
  localparam logic [7:0] MAX_R  = 8'(MAX_RATIO);
  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [2:0] sync_pipe;  // [0]=s0, [1]=s1, [2]=s1_d
  logic       rise;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] hcnt, hcnt_nxt;
  logic [3:0] match, match_nxt, match_inc;
  logic [7:0] ratio, ratio_nxt;
  logic [7:0] high_cnt, high_nxt;
  logic       valid, valid_nxt;
  logic       locked, locked_nxt;
  logic       timeout, timeout_nxt;

  assign rise      = sync_pipe[1] & ~sync_pipe[2];
  assign match_inc = (match >= LOCK_C) ? LOCK_C : match + 4'd1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt == MAX_R) ? cnt : cnt + 8'd1;
    hcnt_nxt    = (sync_pipe[1] && hcnt != MAX_R) ? hcnt + 8'd1 : hcnt;
    match_nxt   = match;
    ratio_nxt   = ratio;
    high_nxt    = high_cnt;
    valid_nxt   = 1'b0;
    locked_nxt  = locked;
    timeout_nxt = timeout;

    if (rise) begin
      cnt_nxt  = 8'd1;
      hcnt_nxt = 8'd1;
    end

    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        hcnt_nxt    = '0;
        match_nxt   = '0;
        locked_nxt  = 1'b0;
        timeout_nxt = 1'b0;
        state_nxt   = ACQUIRE;
      end
      ACQUIRE: begin
        // First edge only aligns the counters; it closes no period.
        if (rise) begin
          state_nxt   = MEASURE;
          timeout_nxt = 1'b0;
        end
      end
      MEASURE, LOCKED: begin
        if (rise) begin
          ratio_nxt = cnt;
          high_nxt  = hcnt;
          valid_nxt = 1'b1;
          // match == 0 means no previous period since ACQUIRE.
          match_nxt = (match != '0 && cnt == ratio) ? match_inc : 4'd1;
          if (match_nxt == LOCK_C) begin
            state_nxt  = LOCKED;
            locked_nxt = 1'b1;
          end else begin
            state_nxt  = MEASURE;
            locked_nxt = 1'b0;
          end
        end else if (cnt == MAX_R) begin
          // An edge in the saturation cycle still counts as a measurement.
          state_nxt   = ACQUIRE;
          timeout_nxt = 1'b1;
          locked_nxt  = 1'b0;
          match_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Disable discards any partial measurement; results hold.
    if (!bus.i_en) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      hcnt_nxt    = '0;
      match_nxt   = '0;
      ratio_nxt   = ratio;
      high_nxt    = high_cnt;
      valid_nxt   = 1'b0;
      locked_nxt  = 1'b0;
      timeout_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      sync_pipe <= '0;
      cnt       <= '0;
      hcnt      <= '0;
      match     <= '0;
      ratio     <= '0;
      high_cnt  <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], bus.i_meas_clk};
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      match     <= match_nxt;
      ratio     <= ratio_nxt;
      high_cnt  <= high_nxt;
      valid     <= valid_nxt;
      locked    <= locked_nxt;
      timeout   <= timeout_nxt;
    end
  end

  assign bus.o_ratio    = ratio;
  assign bus.o_high_cnt = high_cnt;
  assign bus.o_valid    = valid;
  assign bus.o_locked   = locked;
  assign bus.o_timeout  = timeout;
endmodule
